// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host command sequencer.
package ps2_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_TX  = 2'd2,
        WAIT_ACK = 2'd3
    } ps2_state_e;

    // Device response bytes
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERROR  = 8'hFC;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_DEVICE  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_RETRY   = 2'b11;

endpackage

// File: rtl/ps2_cmd_ctrl_if.sv
// Command push port: producer offers bytes, sequencer reports space and level.
interface ps2_cmd_ctrl_if #(
    parameter int FIFO_DEPTH = 4
) ();
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             cmd_valid;
    logic [7:0]       cmd_data;
    logic             cmd_ready;
    logic [LVL_W-1:0] fifo_level;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready,
        input  fifo_level
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready,
        output fifo_level
    );
endinterface

// File: rtl/ps2_cmd_fifo.sv
// Small synchronous command FIFO; head byte is visible until popped.
module ps2_cmd_fifo #(
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       head,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign head    = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Control state; reset flushes the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host command sequencer: issues queued bytes, waits for the device
// response, retires on ACK/ERROR/timeout and re-sends on RESEND.
module ps2_cmd_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 1_000_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ps2_cmd_ctrl_if.slave        cmd_if,
    output logic                 wr_ps2,
    output logic [7:0]           din,
    input  logic                 tx_idle,
    input  logic                 tx_done_tick,
    input  logic                 rx_done_tick,
    input  logic [7:0]           rx_data,
    output logic                 busy,
    output logic                 ack_ok,
    output logic                 err,
    output logic [1:0]           err_code
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    ps2_state_e       state_q, state_d;
    logic [7:0]       din_q, din_d;
    logic             wr_ps2_q, wr_ps2_d;
    logic             ack_ok_q, ack_ok_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [RTY_W-1:0] retry_q, retry_d;

    logic             fifo_pop;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;

    ps2_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_if.cmd_valid),
        .push_data (cmd_if.cmd_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign cmd_if.cmd_ready  = !fifo_full;
    assign cmd_if.fifo_level = fifo_level;

    assign wr_ps2   = wr_ps2_q;
    assign din      = din_q;
    assign ack_ok   = ack_ok_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;

    // Next-state logic; a recognised response takes priority over timer expiry
    always_comb begin
        state_d    = state_q;
        din_d      = din_q;
        wr_ps2_d   = 1'b0;
        ack_ok_d   = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        timer_d    = timer_q;
        retry_d    = retry_q;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && tx_idle) begin
                    din_d    = fifo_head;
                    wr_ps2_d = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = TMR_LOAD;
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (tx_done_tick) begin
                    timer_d = TMR_LOAD;
                    state_d = WAIT_ACK;
                end else if (timer_q == '0) begin
                    fifo_pop   = 1'b1;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    retry_d    = '0;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            WAIT_ACK: begin
                if (rx_done_tick && rx_data == PS2_ACK) begin
                    fifo_pop = 1'b1;
                    ack_ok_d = 1'b1;
                    retry_d  = '0;
                    state_d  = IDLE;
                end else if (rx_done_tick && rx_data == PS2_RESEND) begin
                    if (retry_q < RTY_MAX) begin
                        // Head stays in place and is re-issued from IDLE
                        retry_d = retry_q + 1'b1;
                        state_d = IDLE;
                    end else begin
                        fifo_pop   = 1'b1;
                        err_d      = 1'b1;
                        err_code_d = ERR_RETRY;
                        retry_d    = '0;
                        state_d    = IDLE;
                    end
                end else if (rx_done_tick && rx_data == PS2_ERROR) begin
                    fifo_pop   = 1'b1;
                    err_d      = 1'b1;
                    err_code_d = ERR_DEVICE;
                    retry_d    = '0;
                    state_d    = IDLE;
                end else if (timer_q == '0) begin
                    // Unrecognised bytes do not count as a response
                    fifo_pop   = 1'b1;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    retry_d    = '0;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset aborts any transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            din_q      <= 8'h00;
            wr_ps2_q   <= 1'b0;
            ack_ok_q   <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            timer_q    <= '0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            din_q      <= din_d;
            wr_ps2_q   <= wr_ps2_d;
            ack_ok_q   <= ack_ok_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
        end
    end

endmodule
